// File: rtl/serial_sub_pkg.sv
// +----------------------------------------------------------------------+
// | serial_sub_pkg: shared state encoding and counter sizing helper      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit counter width; a 1-bit operand still needs a 1-bit counter.
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fs_cell.sv
// +----------------------------------------------------------------------+
// | fs_cell: combinational single-bit full subtractor (x - y - bi)       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fs_cell (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// +----------------------------------------------------------------------+
// | serial_subtractor: bit-serial a - b - bin, LSB first, valid/ready.   |
// | SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.  Rev: 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int             CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             brw_q, brw_d;
   logic             bo_q, bo_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             cell_d, cell_bo;
`ifdef SERIAL_SUB_OVF_EN
   logic             sa_sign_q, sa_sign_d;
   logic             sb_sign_q, sb_sign_d;
   logic             ovf_q, ovf_d;
`endif

   fs_cell u_cell (
      .x  (sa_q[0]),
      .y  (sb_q[0]),
      .bi (brw_q),
      .d  (cell_d),
      .bo (cell_bo)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sa_d        = sa_q;
      sb_d        = sb_q;
      res_d       = res_q;
      brw_d       = brw_q;
      bo_d        = bo_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
`ifdef SERIAL_SUB_OVF_EN
      sa_sign_d   = sa_sign_q;
      sb_sign_d   = sb_sign_q;
      ovf_d       = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sa_d       = a;
               sb_d       = b;
               brw_d      = bin;
               cnt_d      = '0;
               in_ready_d = 1'b0;
               state_d    = RUN;
`ifdef SERIAL_SUB_OVF_EN
               sa_sign_d  = a[WIDTH-1];
               sb_sign_d  = b[WIDTH-1];
`endif
            end
         end
         RUN: begin
            // New bit enters at the MSB so the first bit ends up at bit 0.
            res_d = (res_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            brw_d = cell_bo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               cnt_d       = '0;
               bo_d        = cell_bo;
               out_valid_d = 1'b1;
               state_d     = DONE;
`ifdef SERIAL_SUB_OVF_EN
               ovf_d       = (sa_sign_q != sb_sign_q) && (cell_d != sa_sign_q);
`endif
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sa_q        <= '0;
         sb_q        <= '0;
         res_q       <= '0;
         brw_q       <= 1'b0;
         bo_q        <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         sa_sign_q   <= 1'b0;
         sb_sign_q   <= 1'b0;
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sa_q        <= sa_d;
         sb_q        <= sb_d;
         res_q       <= res_d;
         brw_q       <= brw_d;
         bo_q        <= bo_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
`ifdef SERIAL_SUB_OVF_EN
         sa_sign_q   <= sa_sign_d;
         sb_sign_q   <= sb_sign_d;
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign diff       = res_q;
   assign borrow_out = bo_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf        = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// +----------------------------------------------------------------------+
// | tb_serial_subtractor: directed vectors, corner sequences and random  |
// | handshake traffic on WIDTH 8, 1 and 33 instances. Revision: 1.0      |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_serial_subtractor;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         in_valid, in_ready, bin, out_valid, out_ready, borrow_out, ovf;
   logic [W-1:0] a, b, diff;
   logic         iv1, ir1, bin1, ov1, or1, bo1, ovf1;
   logic [0:0]   a1, b1, d1;
   logic         iv33, ir33, bin33, ov33, or33, bo33, ovf33;
   logic [32:0]  a33, b33, d33;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
      , .ovf(ovf)
`endif
   );

   serial_subtractor #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
      .a(a1), .b(b1), .bin(bin1), .out_valid(ov1), .out_ready(or1),
      .diff(d1), .borrow_out(bo1)
`ifdef SERIAL_SUB_OVF_EN
      , .ovf(ovf1)
`endif
   );

   serial_subtractor #(.WIDTH(33)) dut33 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv33), .in_ready(ir33),
      .a(a33), .b(b33), .bin(bin33), .out_valid(ov33), .out_ready(or33),
      .diff(d33), .borrow_out(bo33)
`ifdef SERIAL_SUB_OVF_EN
      , .ovf(ovf33)
`endif
   );

`ifndef SERIAL_SUB_OVF_EN
   assign ovf   = 1'b0;
   assign ovf1  = 1'b0;
   assign ovf33 = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] d;
      logic       bo;
      logic       ovf;
   } vec_t;

   vec_t vecs[9];

   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                         input logic [7:0] ed, input logic ebo, input logic eovf);
      int lat;
      @(negedge clk);
      a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
      check("accept in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("run in_ready", in_ready, 0);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", lat, W + 1);
      check("diff", diff, ed);
      check("borrow_out", borrow_out, ebo);
`ifdef SERIAL_SUB_OVF_EN
      check("ovf", ovf, eovf);
`else
      if (eovf === 1'bx) check("ovf tie", ovf, 0);
`endif
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("pop out_valid", out_valid, 0);
      check("pop in_ready", in_ready, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      logic [63:0] r64;
      logic [8:0]  t8;
      logic [1:0]  t1;
      logic [33:0] t33;
      logic        p8, p1, p33, e8bo, e1bo, e33bo, e8ovf, e1ovf, e33ovf;
      logic [7:0]  e8d;
      logic [0:0]  e1d;
      logic [32:0] e33d;
      int          ops, lat;

      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
      vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
      vecs[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
      vecs[4] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
      vecs[5] = '{8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b0, 1'b0};
      vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[7] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};
      vecs[8] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};

      in_valid = 0; out_ready = 0; a = '0; b = '0; bin = 0;
      iv1 = 0; or1 = 0; a1 = '0; b1 = '0; bin1 = 0;
      iv33 = 0; or33 = 0; a33 = '0; b33 = '0; bin33 = 0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset diff", diff, 0);
      check("reset borrow_out", borrow_out, 0);
      check("reset ovf", ovf, 0);
      check("reset w1 in_ready", ir1, 1);
      check("reset w33 out_valid", ov33, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, vecs[i].ovf);

      // Backpressure with a competing offer held throughout
      @(negedge clk);
      a = 8'h33; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("bp latency", lat, W + 1);
      @(negedge clk);
      a = 8'hAA; b = 8'h01; bin = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         check("bp out_valid", out_valid, 1);
         check("bp in_ready", in_ready, 0);
         check("bp diff", diff, 8'h22);
         check("bp borrow_out", borrow_out, 0);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp pop in_ready", in_ready, 1);
      check("bp pop diff kept", diff, 8'h22);
      @(posedge clk);
      #1;
      check("bp no accept", in_ready, 1);

      // Reset in the 4th RUN cycle
      @(negedge clk);
      a = 8'h5A; b = 8'h3C; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst in_ready", in_ready, 1);
      check("midrst out_valid", out_valid, 0);
      check("midrst diff", diff, 0);
      check("midrst borrow_out", borrow_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (W + 4) begin
         @(posedge clk);
         #1;
         if (out_valid) check("midrst no result", out_valid, 0);
      end
      run_op(8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b0, 1'b0);

      // Random traffic on all three widths
      p8 = 0; p1 = 0; p33 = 0; ops = 0;
      e8d = '0; e8bo = 0; e8ovf = 0; e1d = '0; e1bo = 0; e1ovf = 0;
      e33d = '0; e33bo = 0; e33ovf = 0;
      for (int c = 0; c < 7000; c++) begin
         @(negedge clk);
         r = $urandom;
         in_valid = (r[1:0] != 2'b00); out_ready = (r[3:2] != 2'b00);
         iv1 = (r[5:4] != 2'b00);      or1 = (r[7:6] != 2'b00);
         iv33 = (r[9:8] != 2'b00);     or33 = (r[11:10] != 2'b00);
         bin = r[12]; bin1 = r[13]; bin33 = r[14];
         a1 = r[15]; b1 = r[16];
         r = $urandom; a = r[7:0]; b = r[15:8];
         r64 = {$urandom, $urandom}; a33 = r64[32:0];
         r64 = {$urandom, $urandom}; b33 = r64[32:0];
         #1;
         if (out_valid && out_ready) begin
            check("rand8 pending", p8, 1);
            check("rand8 diff", diff, e8d);
            check("rand8 borrow", borrow_out, e8bo);
`ifdef SERIAL_SUB_OVF_EN
            check("rand8 ovf", ovf, e8ovf);
`endif
            p8 = 0; ops++;
         end
         if (ov1 && or1) begin
            check("rand1 pending", p1, 1);
            check("rand1 diff", d1, e1d);
            check("rand1 borrow", bo1, e1bo);
`ifdef SERIAL_SUB_OVF_EN
            check("rand1 ovf", ovf1, e1ovf);
`endif
            p1 = 0; ops++;
         end
         if (ov33 && or33) begin
            check("rand33 pending", p33, 1);
            check("rand33 diff", d33, e33d);
            check("rand33 borrow", bo33, e33bo);
`ifdef SERIAL_SUB_OVF_EN
            check("rand33 ovf", ovf33, e33ovf);
`endif
            p33 = 0; ops++;
         end
         if (in_valid && in_ready) begin
            t8 = {1'b0, a} - {1'b0, b} - {8'd0, bin};
            e8d = t8[7:0]; e8bo = t8[8];
            e8ovf = (a[7] != b[7]) && (t8[7] != a[7]);
            p8 = 1;
         end
         if (iv1 && ir1) begin
            t1 = {1'b0, a1} - {1'b0, b1} - {1'b0, bin1};
            e1d = t1[0:0]; e1bo = t1[1];
            e1ovf = (a1[0] != b1[0]) && (t1[0] != a1[0]);
            p1 = 1;
         end
         if (iv33 && ir33) begin
            t33 = {1'b0, a33} - {1'b0, b33} - {33'd0, bin33};
            e33d = t33[32:0]; e33bo = t33[33];
            e33ovf = (a33[32] != b33[32]) && (t33[32] != a33[32]);
            p33 = 1;
         end
      end
      @(negedge clk);
      in_valid = 0; iv1 = 0; iv33 = 0;
      check("rand op count", (ops >= 1000), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
